// File: rtl/tcdm_bank_responder_pkg.sv
// Shared helpers for the TCDM bank responder and its response FIFO.
// Only default values and width helpers live here; every width is derived
// from module parameters at the point of use.
package tcdm_bank_responder_pkg;

  localparam int unsigned DefaultNumIn        = 32;
  localparam int unsigned DefaultAddrMemWidth = 12;
  localparam int unsigned DefaultDataWidth    = 32;
  localparam int unsigned DefaultMemLatency   = 1;
  localparam int unsigned DefaultRespDepth    = 3;

  // Bits needed to index 'depth' storage slots (at least one bit).
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold any count in 0..max_val (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Circular-buffer FIFO with the common_cells fifo_v3 behaviour: with
// FALL_THROUGH=0 the head is read straight from the storage registers, so a
// pushed word becomes visible one cycle after the push.
module fifo_v3
  import tcdm_bank_responder_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = ptr_bits(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] PtrLast = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   CntFull = (ADDR_DEPTH + 1)'(DEPTH);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);

  // Pointer / occupancy update and head selection.
  always_comb begin
    // NOTE: defaults first, so no branch can leave a signal unassigned and infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    data_o   = mem_q[rd_ptr_q];

    if (push_i && !full_o) begin
      mem_we   = 1'b1;
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      cnt_d    = cnt_d - 1'b1;
    end
    // Fall-through: an empty FIFO forwards the incoming word and, if it is
    // consumed in the same cycle, nothing is stored.
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        mem_we   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
      end
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      mem_we   = 1'b0;
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; occupancy guards every read, and consumers mask the head while empty.
    if (mem_we) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: grants requests against a pool of response credits,
// forwards each access to the SRAM, tracks accesses in flight with a
// MemLatency-deep shift pipeline and returns one in-order response per
// accepted request through a registered response FIFO.
module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned NumIn        = DefaultNumIn,
  parameter int unsigned AddrMemWidth = DefaultAddrMemWidth,
  parameter int unsigned DataWidth    = DefaultDataWidth,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned MemLatency   = DefaultMemLatency,
  parameter int unsigned RespDepth    = DefaultRespDepth,
  localparam int unsigned TagWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // request side
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [TagWidth-1:0]     ini_add_i,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  // response side
  output logic                    vld_o,
  input  logic                    rdy_i,
  output logic [TagWidth-1:0]     ini_add_o,
  output logic [DataWidth-1:0]    rdata_o,
  // memory side
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrMemWidth-1:0] mem_add_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned CntWidth  = cnt_bits(RespDepth);
  localparam int unsigned FifoWidth = TagWidth + DataWidth;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(RespDepth);

  if (MemLatency < 1) begin : g_bad_latency
    $fatal(1, "tcdm_bank_responder: MemLatency must be >= 1");
  end
  if (RespDepth < 1) begin : g_bad_depth
    $fatal(1, "tcdm_bank_responder: RespDepth must be >= 1");
  end

  logic                  accept, handshake;
  logic [CntWidth-1:0]   credit_q, credit_d;
  logic [MemLatency-1:0] pipe_vld_q, pipe_vld_d;
  logic [MemLatency-1:0] pipe_we_q, pipe_we_d;
  logic [TagWidth-1:0]   pipe_tag_q [MemLatency];
  logic [TagWidth-1:0]   pipe_tag_d [MemLatency];
  logic [DataWidth-1:0]  resp_rdata;
  logic                  fifo_push, fifo_full, fifo_empty;
  logic [FifoWidth-1:0]  fifo_wdata, fifo_rdata;
  logic [TagWidth-1:0]   head_tag;
  logic [DataWidth-1:0]  head_data;

  // A credit is reserved when a request is accepted and released when its
  // response is handed over, so the grant only depends on registered state.
  assign gnt_o     = (credit_q < CntMax);
  assign accept    = req_i && gnt_o;
  assign handshake = vld_o && rdy_i;

  // The SRAM sees the request directly; only the strobe is qualified by the grant.
  assign mem_req_o   = accept;
  assign mem_we_o    = wen_i;
  assign mem_add_o   = add_i;
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  // Credit counter next state: +1 on accept, -1 on handshake, hold on both.
  always_comb begin
    credit_d = credit_q;
    unique case ({accept, handshake})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // In-flight pipeline next state: stage 0 captures the accepted access.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_we_d     = '0;
    pipe_vld_d[0] = accept;
    pipe_we_d[0]  = wen_i;
    pipe_tag_d[0] = ini_add_i;
    for (int i = 1; i < MemLatency; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_we_d[i]  = pipe_we_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  // Credit counter and in-flight pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q   <= '0;
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
      for (int i = 0; i < MemLatency; i++) begin
        pipe_tag_q[i] <= '0;
      end
    end else begin
      credit_q   <= credit_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_we_q  <= pipe_we_d;
      for (int i = 0; i < MemLatency; i++) begin
        pipe_tag_q[i] <= pipe_tag_d[i];
      end
    end
  end

  // The pipeline tail lines up with the SRAM read data; writes answer zero.
  always_comb begin
    resp_rdata = pipe_we_q[MemLatency-1] ? '0 : mem_rdata_i;
    fifo_push  = pipe_vld_q[MemLatency-1];
    fifo_wdata = {pipe_tag_q[MemLatency-1], resp_rdata};
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (FifoWidth),
    .DEPTH        (RespDepth)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (fifo_wdata),
    .push_i  (fifo_push),
    .data_o  (fifo_rdata),
    .pop_i   (handshake)
  );

  // Response port: head of the FIFO, forced to zero while nothing is buffered.
  always_comb begin
    {head_tag, head_data} = fifo_rdata;
    vld_o     = !fifo_empty;
    ini_add_o = vld_o ? head_tag  : '0;
    rdata_o   = vld_o ? head_data : '0;
  end

  // A push always consumes a credit reserved at acceptance, so the FIFO cannot overflow.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && fifo_full));
  a_credit_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_q <= CntMax);

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: DUT a (MemLatency=1) for the directed
// scenarios, DUT b (MemLatency=2) for the randomised stall scenario.
module tb_tcdm_bank_responder;

  localparam int TW = 5;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int Depth = 3;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // SRAM content model: fixed function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 12'h010) return 32'hDEADBEEF;
    return {a, 8'hA5, ~a};
  endfunction

  // ---------------- DUT a ----------------
  logic          a_req = 0, a_wen = 0, a_rdy = 0;
  logic [TW-1:0] a_tag = '0;
  logic [AW-1:0] a_add = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [BW-1:0] a_be = '0;
  logic          a_gnt, a_vld, a_mreq, a_mwe;
  logic [TW-1:0] a_itag;
  logic [DW-1:0] a_rdata, a_mwdata, a_mrdata;
  logic [AW-1:0] a_madd;
  logic [BW-1:0] a_mbe;
  logic [DW-1:0] a_mpipe;

  always @(posedge clk) a_mpipe <= mem_fn(a_madd);
  assign a_mrdata = a_mpipe;

  tcdm_bank_responder #(
    .NumIn(32), .AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .MemLatency(1), .RespDepth(Depth)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(a_req), .gnt_o(a_gnt), .ini_add_i(a_tag), .add_i(a_add),
    .wen_i(a_wen), .wdata_i(a_wdata), .be_i(a_be),
    .vld_o(a_vld), .rdy_i(a_rdy), .ini_add_o(a_itag), .rdata_o(a_rdata),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_add_o(a_madd),
    .mem_wdata_o(a_mwdata), .mem_be_o(a_mbe), .mem_rdata_i(a_mrdata)
  );

  // ---------------- DUT b ----------------
  logic          b_req = 0, b_wen = 0, b_rdy = 0;
  logic [TW-1:0] b_tag = '0;
  logic [AW-1:0] b_add = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [BW-1:0] b_be = '0;
  logic          b_gnt, b_vld, b_mreq, b_mwe;
  logic [TW-1:0] b_itag;
  logic [DW-1:0] b_rdata, b_mwdata, b_mrdata;
  logic [AW-1:0] b_madd;
  logic [BW-1:0] b_mbe;
  logic [DW-1:0] b_mpipe0, b_mpipe1;

  always @(posedge clk) begin
    b_mpipe0 <= mem_fn(b_madd);
    b_mpipe1 <= b_mpipe0;
  end
  assign b_mrdata = b_mpipe1;

  tcdm_bank_responder #(
    .NumIn(32), .AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .MemLatency(2), .RespDepth(Depth)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(b_req), .gnt_o(b_gnt), .ini_add_i(b_tag), .add_i(b_add),
    .wen_i(b_wen), .wdata_i(b_wdata), .be_i(b_be),
    .vld_o(b_vld), .rdy_i(b_rdy), .ini_add_o(b_itag), .rdata_o(b_rdata),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_add_o(b_madd),
    .mem_wdata_o(b_mwdata), .mem_be_o(b_mbe), .mem_rdata_i(b_mrdata)
  );

  resp_t sb_a[$];
  resp_t sb_b[$];

  task automatic drive_a(input logic req, input logic [TW-1:0] tag, input logic [AW-1:0] add,
                         input logic wen, input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    a_req = req; a_tag = tag; a_add = add; a_wen = wen; a_wdata = wdata; a_be = be;
  endtask

  // Outputs while reset is held and right after release.
  task automatic test_reset;
    rst_n = 1'b0;
    drive_a(1'b1, 5'd7, 12'h3, 1'b0, '0, 4'hF);
    @(negedge clk); #1;
    n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", a_vld); end
    n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL reset_gnt: got %b want 1", a_gnt); end
    n_vec++; if (a_mreq !== 1'b1) begin n_err++; $display("FAIL reset_mem_req_follows_req: got %b want 1", a_mreq); end
    n_vec++; if (a_itag !== '0) begin n_err++; $display("FAIL reset_tag: got %0d want 0", a_itag); end
    n_vec++; if (a_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
    n_vec++; if (b_vld !== 1'b0 || b_gnt !== 1'b1) begin n_err++; $display("FAIL reset_b: got vld=%b gnt=%b want 0/1", b_vld, b_gnt); end
    a_req = 1'b0; #1;
    n_vec++; if (a_mreq !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_idle: got %b want 0", a_mreq); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++; if (a_vld !== 1'b0 || a_gnt !== 1'b1) begin n_err++; $display("FAIL post_reset: got vld=%b gnt=%b want 0/1", a_vld, a_gnt); end
  endtask

  // One read, tag 5, addr 0x010: response two cycles after the access.
  task automatic test_single_read;
    @(negedge clk); a_rdy = 1'b0; drive_a(1'b1, 5'd5, 12'h010, 1'b0, '0, 4'hF); #1;
    n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b want 1", a_gnt); end
    n_vec++; if (a_mreq !== 1'b1 || a_mwe !== 1'b0) begin n_err++; $display("FAIL rd_mem_ctrl: got req=%b we=%b want 1/0", a_mreq, a_mwe); end
    n_vec++; if (a_madd !== 12'h010) begin n_err++; $display("FAIL rd_mem_add: got %h want 010", a_madd); end
    @(negedge clk); a_req = 1'b0; #1;
    n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL rd_vld_cycle1: got %b want 0", a_vld); end
    @(negedge clk); a_rdy = 1'b1; #1;
    n_vec++; if (a_vld !== 1'b1) begin n_err++; $display("FAIL rd_vld_cycle2: got %b want 1", a_vld); end
    n_vec++; if (a_itag !== 5'd5) begin n_err++; $display("FAIL rd_tag: got %0d want 5", a_itag); end
    n_vec++; if (a_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", a_rdata); end
    @(negedge clk); a_rdy = 1'b0; #1;
    n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL rd_vld_after_pop: got %b want 0", a_vld); end
  endtask

  // One write, tag 3: pass-through to the SRAM and a zero-data response.
  task automatic test_write;
    @(negedge clk); drive_a(1'b1, 5'd3, 12'h020, 1'b1, 32'h12345678, 4'hF); #1;
    n_vec++; if (a_mreq !== 1'b1 || a_mwe !== 1'b1) begin n_err++; $display("FAIL wr_mem_ctrl: got req=%b we=%b want 1/1", a_mreq, a_mwe); end
    n_vec++; if (a_mwdata !== 32'h12345678 || a_mbe !== 4'hF || a_madd !== 12'h020) begin
      n_err++; $display("FAIL wr_passthru: got d=%h be=%h a=%h want 12345678/f/020", a_mwdata, a_mbe, a_madd); end
    @(negedge clk); a_req = 1'b0; #1;
    @(negedge clk); a_rdy = 1'b1; #1;
    n_vec++; if (a_vld !== 1'b1 || a_itag !== 5'd3 || a_rdata !== '0) begin
      n_err++; $display("FAIL wr_resp: got vld=%b tag=%0d d=%h want 1/3/0", a_vld, a_itag, a_rdata); end
    @(negedge clk); a_rdy = 1'b0; #1;
  endtask

  // Credits exhaust with rdy low; drain returns tags in order, grant reopens after first pop.
  task automatic test_credit_stall;
    int acc = 0;
    resp_t exp;
    a_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_a(1'b1, TW'(c + 8), AW'(12'h100 + c), 1'b0, '0, 4'hF); #1;
      n_vec++; if (a_gnt !== (c < 3)) begin n_err++; $display("FAIL stall_gnt_c%0d: got %b want %b", c, a_gnt, (c < 3)); end
      if (a_gnt && a_req) begin acc++; sb_a.push_back('{tag: a_tag, data: mem_fn(a_add)}); end
    end
    n_vec++; if (acc != 3) begin n_err++; $display("FAIL stall_accepted: got %0d want 3", acc); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); a_req = 1'b0; a_rdy = 1'b1; #1;
      n_vec++; if (a_gnt !== (k > 0)) begin n_err++; $display("FAIL drain_gnt_k%0d: got %b want %b", k, a_gnt, (k > 0)); end
      if (sb_a.size() == 0) begin
        n_vec++; n_err++; $display("FAIL drain_sb_underflow: got empty want entry");
      end else begin
        exp = sb_a.pop_front();
        n_vec++; if (a_vld !== 1'b1 || a_itag !== exp.tag || a_rdata !== exp.data) begin
          n_err++; $display("FAIL drain_resp_k%0d: got vld=%b tag=%0d d=%h want 1/%0d/%h", k, a_vld, a_itag, a_rdata, exp.tag, exp.data); end
      end
    end
    @(negedge clk); a_rdy = 1'b0; #1;
    n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", a_vld); end
  endtask

  // 20 back-to-back requests with rdy high: a grant every cycle, in-order responses.
  task automatic test_back_to_back;
    int grants = 0;
    int cyc = 0;
    resp_t exp;
    logic [DW-1:0] ed;
    sb_a.delete();
    while ((cyc < 20 || sb_a.size() != 0) && cyc < 60) begin
      @(negedge clk);
      a_rdy = 1'b1;
      if (cyc < 20) drive_a(1'b1, TW'(cyc), AW'($urandom_range(4095)), 1'($urandom_range(1)), $urandom, 4'hF);
      else a_req = 1'b0;
      #1;
      n_vec++; if (a_gnt !== (sb_a.size() < Depth)) begin n_err++; $display("FAIL b2b_gnt_c%0d: got %b want %b", cyc, a_gnt, (sb_a.size() < Depth)); end
      if (cyc < 20) begin
        n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_throughput_c%0d: got gnt=%b want 1", cyc, a_gnt); end
      end
      if (a_vld && a_rdy) begin
        if (sb_a.size() == 0) begin
          n_vec++; n_err++; $display("FAIL b2b_spurious: got tag=%0d want none", a_itag);
        end else begin
          exp = sb_a.pop_front();
          n_vec++; if (a_itag !== exp.tag || a_rdata !== exp.data) begin
            n_err++; $display("FAIL b2b_resp: got %0d/%h want %0d/%h", a_itag, a_rdata, exp.tag, exp.data); end
        end
      end
      if (a_gnt && a_req) begin
        grants++;
        ed = a_wen ? '0 : mem_fn(a_add);
        sb_a.push_back('{tag: a_tag, data: ed});
      end
      cyc++;
    end
    n_vec++; if (grants != 20) begin n_err++; $display("FAIL b2b_grants: got %0d want 20", grants); end
    n_vec++; if (sb_a.size() != 0) begin n_err++; $display("FAIL b2b_leftover: got %0d want 0", sb_a.size()); end
    @(negedge clk); a_rdy = 1'b0; a_req = 1'b0;
  endtask

  // MemLatency=2, random rdy and traffic, 1000 requests; payload held under stall.
  task automatic test_random_stall;
    int issued = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [TW-1:0] prev_tag = '0;
    logic [DW-1:0] prev_data = '0;
    resp_t exp;
    sb_b.delete();
    while ((issued < 1000 || sb_b.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      b_req = (issued < 1000) && ($urandom_range(3) != 0);
      b_tag = TW'($urandom_range(31));
      b_add = AW'($urandom_range(4095));
      b_wen = 1'($urandom_range(1));
      b_wdata = $urandom;
      b_be = BW'($urandom_range(15));
      b_rdy = 1'($urandom_range(1));
      #1;
      if (prev_stall) begin
        n_vec++; if (b_vld !== 1'b1 || b_itag !== prev_tag || b_rdata !== prev_data) begin
          n_err++; $display("FAIL rnd_stable_c%0d: got %b/%0d/%h want 1/%0d/%h", cyc, b_vld, b_itag, b_rdata, prev_tag, prev_data); end
      end
      n_vec++; if (b_gnt !== (sb_b.size() < Depth)) begin n_err++; $display("FAIL rnd_gnt_c%0d: got %b want %b", cyc, b_gnt, (sb_b.size() < Depth)); end
      if (b_vld && b_rdy) begin
        if (sb_b.size() == 0) begin
          n_vec++; n_err++; $display("FAIL rnd_spurious: got tag=%0d want none", b_itag);
        end else begin
          exp = sb_b.pop_front();
          n_vec++; if (b_itag !== exp.tag || b_rdata !== exp.data) begin
            n_err++; $display("FAIL rnd_resp_c%0d: got %0d/%h want %0d/%h", cyc, b_itag, b_rdata, exp.tag, exp.data); end
        end
      end
      if (b_req && b_gnt) begin
        issued++;
        sb_b.push_back('{tag: b_tag, data: (b_wen ? '0 : mem_fn(b_add))});
      end
      prev_stall = b_vld && !b_rdy;
      prev_tag = b_itag;
      prev_data = b_rdata;
      cyc++;
    end
    n_vec++; if (cyc >= 20000) begin n_err++; $display("FAIL rnd_timeout: got %0d issued, %0d pending want 1000/0", issued, sb_b.size()); end
    @(negedge clk); b_req = 1'b0; b_rdy = 1'b0;
  endtask

  // Reset with two buffered responses: they vanish and never reappear.
  task automatic test_reset_mid;
    a_rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); drive_a(1'b1, TW'(20 + c), AW'(12'h200 + c), 1'b0, '0, 4'hF);
    end
    @(negedge clk); a_req = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (a_vld !== 1'b1) begin n_err++; $display("FAIL mid_buffered: got vld=%b want 1", a_vld); end
    #1 rst_n = 1'b0; #1;
    n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL mid_vld_immediate: got %b want 0", a_vld); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1; a_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (a_vld !== 1'b0 || a_gnt !== 1'b1) begin n_err++; $display("FAIL mid_after_c%0d: got vld=%b gnt=%b want 0/1", c, a_vld, a_gnt); end
      @(negedge clk);
    end
    a_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_credit_stall();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
